xpb_accum_seq: RTL and testbench



---
 rtl/xpb_pkg.sv | 22 ++
 rtl/xpb_valid_pipe.sv | 31 +++
 rtl/xpb_accum_seq.sv | 125 ++++++++++++
 tb/tb_xpb_accum_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xpb_pkg.sv
// Shared definitions for the XPB reduction table sequencer: default geometry,
// FSM state encoding and the width helper used to size selects and accumulators.
package xpb_pkg;

  localparam int unsigned DEF_SEG_BITS = 5;
  localparam int unsigned DEF_NUM_SEG  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } xpb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/xpb_valid_pipe.sv
// Valid-bit delay line matching the XPB table read latency; pend_o reports
// whether any valid will still be in flight after the coming edge.
module xpb_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic vld_i,
  output logic vld_o,
  output logic pend_o
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = vld_i;
    for (int unsigned i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    if (flush_i) pipe_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign vld_o  = pipe_q[DEPTH-1];
  assign pend_o = |pipe_d;

endmodule

// File: rtl/xpb_accum_seq.sv
// Issues the squarer's upper-word segments one per cycle to the XPB table bank
// and accumulates the returned residues into a carry-safe sum.
module xpb_accum_seq
  import xpb_pkg::*;
#(
  parameter  int unsigned WIDTH    = 1024,
  parameter  int unsigned SEG_BITS = DEF_SEG_BITS,
  parameter  int unsigned NUM_SEG  = DEF_NUM_SEG,
  parameter  int unsigned LUT_LAT  = 1,
  localparam int unsigned SEL_W    = clog2(NUM_SEG),
  localparam int unsigned ACC_W    = WIDTH + clog2(NUM_SEG + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_SEG*SEG_BITS-1:0] upper_in,
  output logic                        busy,
  output logic [SEL_W-1:0]            lut_seg,
  output logic [SEG_BITS-1:0]         lut_idx,
  input  logic [WIDTH-1:0]            lut_data,
  output logic                        done,
  output logic [ACC_W-1:0]            sum_out
);

  xpb_state_e                  state_q, state_d;
  logic [NUM_SEG*SEG_BITS-1:0] seg_q, seg_d;
  logic [SEL_W-1:0]            cnt_q, cnt_d;
  logic [SEL_W-1:0]            lut_seg_q, lut_seg_d;
  logic [SEG_BITS-1:0]         lut_idx_q, lut_idx_d;
  logic                        issue_vld_q, issue_vld_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [ACC_W-1:0]            sum_q, sum_d;
  logic                        accept, pipe_vld, pipe_pend;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // Segment 0 is issued on the accept edge itself so the registered table
  // address is already valid in the first busy cycle; cnt then runs 1..NUM_SEG-1.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    cnt_d       = cnt_q;
    lut_seg_d   = lut_seg_q;
    lut_idx_d   = lut_idx_q;
    issue_vld_d = 1'b0;
    sum_d       = sum_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d     = ISSUE;
          seg_d       = upper_in;
          lut_seg_d   = '0;
          lut_idx_d   = upper_in[SEG_BITS-1:0];
          issue_vld_d = 1'b1;
          cnt_d       = SEL_W'(1);
        end
      end
      ISSUE: begin
        lut_seg_d   = cnt_q;
        lut_idx_d   = seg_q[cnt_q*SEG_BITS +: SEG_BITS];
        issue_vld_d = 1'b1;
        if (cnt_q == SEL_W'(NUM_SEG - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      DRAIN: begin
        if (!pipe_pend) begin
          state_d = DONE;
          sum_d   = acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (accept)        acc_d = '0;
    else if (pipe_vld) acc_d = acc_q + ACC_W'(lut_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seg_q       <= '0;
      cnt_q       <= '0;
      lut_seg_q   <= '0;
      lut_idx_q   <= '0;
      issue_vld_q <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      cnt_q       <= cnt_d;
      lut_seg_q   <= lut_seg_d;
      lut_idx_q   <= lut_idx_d;
      issue_vld_q <= issue_vld_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
    end
  end

  xpb_valid_pipe #(
    .DEPTH(LUT_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(accept),
    .vld_i  (issue_vld_q),
    .vld_o  (pipe_vld),
    .pend_o (pipe_pend)
  );

  assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign lut_seg = lut_seg_q;
  assign lut_idx = lut_idx_q;
  assign sum_out = sum_q;

endmodule

// File: tb/tb_xpb_accum_seq.sv
// Bench for xpb_accum_seq: registered (seg+1)*idx table model, vector table,
// done-time scoreboard, and corner sequences (back-to-back, ignored start, reset, LUT_LAT=3).
module tb_xpb_accum_seq;

  localparam int unsigned WIDTH = 1024;
  localparam int unsigned SB    = 5;
  localparam int unsigned NS    = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned ACC_W = 1028;
  localparam int unsigned UW    = NS * SB;

  typedef struct {
    logic [ACC_W-1:0] sum;
    int               cyc;
  } exp_t;

  typedef struct {
    logic [UW-1:0]    up;
    logic             ones;
    logic [ACC_W-1:0] sum;
  } vec_t;

  logic clk, rst_n;
  logic start_a, busy_a, done_a, ones_mode;
  logic [UW-1:0] upper_a;
  logic [SEL_W-1:0] lut_seg_a;
  logic [SB-1:0] lut_idx_a;
  logic [WIDTH-1:0] lut_data_a;
  logic [ACC_W-1:0] sum_a;

  logic start_b, busy_b, done_b;
  logic [UW-1:0] upper_b;
  logic [SEL_W-1:0] lut_seg_b;
  logic [SB-1:0] lut_idx_b;
  logic [WIDTH-1:0] lut_data_b, b1, b2;
  logic [ACC_W-1:0] sum_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  xpb_accum_seq #(.WIDTH(WIDTH), .SEG_BITS(SB), .NUM_SEG(NS), .LUT_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .upper_in(upper_a), .busy(busy_a),
    .lut_seg(lut_seg_a), .lut_idx(lut_idx_a), .lut_data(lut_data_a),
    .done(done_a), .sum_out(sum_a)
  );

  xpb_accum_seq #(.WIDTH(WIDTH), .SEG_BITS(SB), .NUM_SEG(NS), .LUT_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .upper_in(upper_b), .busy(busy_b),
    .lut_seg(lut_seg_b), .lut_idx(lut_idx_b), .lut_data(lut_data_b),
    .done(done_b), .sum_out(sum_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] lut_val(input logic [SEL_W-1:0] s, input logic [SB-1:0] i);
    logic [15:0] p;
    p = (16'(s) + 16'd1) * 16'(i);
    return WIDTH'(p);
  endfunction

  always @(posedge clk) lut_data_a <= ones_mode ? '1 : lut_val(lut_seg_a, lut_idx_a);

  always @(posedge clk) begin
    b1         <= lut_val(lut_seg_b, lut_idx_b);
    b2         <= b1;
    lut_data_b <= b2;
  end

  task automatic chk(input string nm, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got hi=%0h lo=%0h want hi=%0h lo=%0h", nm,
               got[ACC_W-1:ACC_W-64], got[63:0], want[ACC_W-1:ACC_W-64], want[63:0]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a) begin
      if (sbq.size() == 0) begin
        chk("done_unexpected", ACC_W'(done_a), '0);
      end else begin
        e = sbq.pop_front();
        chk("done_sum", sum_a, e.sum);
        chk("done_cyc", ACC_W'(cyc), ACC_W'(e.cyc));
      end
    end
  end

  function automatic logic [UW-1:0] ramp(input int off);
    logic [UW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NS); i++) r[i*SB +: SB] = SB'(i + off);
    return r;
  endfunction

  function automatic logic [UW-1:0] fill(input logic [SB-1:0] v);
    logic [UW-1:0] r;
    for (int i = 0; i < int'(NS); i++) r[i*SB +: SB] = v;
    return r;
  endfunction

  task automatic start_op(input logic [UW-1:0] up, input logic ones, input logic [ACC_W-1:0] sum,
                          input bit push, output int s);
    exp_t e;
    s         = cyc;
    start_a   = 1'b1;
    upper_a   = up;
    ones_mode = ones;
    if (push) begin
      e.sum = sum;
      e.cyc = s + 10;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    upper_a = UW'({$urandom, $urandom});
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int s;
    logic [UW-1:0] upv;
    upv = v.up;
    start_op(v.up, v.ones, v.sum, 1'b1, s);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_busy_c%0d", n, k), ACC_W'(busy_a), ACC_W'(k <= 9));
      chk($sformatf("v%0d_done_c%0d", n, k), ACC_W'(done_a), ACC_W'(k == 10));
      if (k <= 8) begin
        chk($sformatf("v%0d_seg_c%0d", n, k), ACC_W'(lut_seg_a), ACC_W'(k - 1));
        chk($sformatf("v%0d_idx_c%0d", n, k), ACC_W'(lut_idx_a), ACC_W'(upv[(k-1)*SB +: SB]));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    logic [ACC_W-1:0] big;
    int s, got;
    exp_t e;

    big = '0;
    big[WIDTH+3] = 1'b1;
    big = big - ACC_W'(8);

    vt[0] = '{up: '0,           ones: 1'b0, sum: ACC_W'(0)};
    vt[1] = '{up: fill(5'd31),  ones: 1'b0, sum: ACC_W'(1116)};
    vt[2] = '{up: ramp(1),      ones: 1'b0, sum: ACC_W'(204)};
    vt[3] = '{up: ramp(0),      ones: 1'b0, sum: ACC_W'(168)};
    vt[4] = '{up: ramp(3),      ones: 1'b1, sum: big};
    vt[5] = '{up: UW'(5'd31),   ones: 1'b0, sum: ACC_W'(31)};
    vt[6] = '{up: {5'd31, 35'd0}, ones: 1'b0, sum: ACC_W'(248)};

    rst_n = 1'b0; start_a = 1'b0; upper_a = '0; ones_mode = 1'b0;
    start_b = 1'b0; upper_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", ACC_W'(busy_a), '0);
    chk("rst_done", ACC_W'(done_a), '0);
    chk("rst_seg",  ACC_W'(lut_seg_a), '0);
    chk("rst_idx",  ACC_W'(lut_idx_a), '0);
    chk("rst_sum",  sum_a, '0);
    @(posedge clk); #1;

    for (int n = 0; n < 7; n++) run_vec(vt[n], n);

    // back-to-back: start held high across the DONE cycle
    s = cyc;
    start_a = 1'b1; upper_a = ramp(1); ones_mode = 1'b0;
    e.sum = ACC_W'(204); e.cyc = s + 10; sbq.push_back(e);
    e.sum = ACC_W'(36);  e.cyc = s + 20; sbq.push_back(e);
    @(posedge clk); #1;
    upper_a = fill(5'd1);
    repeat (10) @(posedge clk); #1;
    start_a = 1'b0; upper_a = '0;
    chk("b2b_busy_second", ACC_W'(busy_a), ACC_W'(1));
    repeat (11) @(posedge clk); #1;

    // starts while busy are ignored
    start_op(ramp(0), 1'b0, ACC_W'(168), 1'b1, s);
    repeat (2) @(posedge clk); #1;
    start_a = 1'b1; upper_a = fill(5'd31);
    @(posedge clk); #1; start_a = 1'b0;
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (7) @(posedge clk); #1;

    // reset mid-operation
    start_op(ramp(1), 1'b0, '0, 1'b0, s);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", ACC_W'(busy_a), '0);
    chk("mid_rst_done", ACC_W'(done_a), '0);
    chk("mid_rst_seg",  ACC_W'(lut_seg_a), '0);
    chk("mid_rst_idx",  ACC_W'(lut_idx_a), '0);
    chk("mid_rst_sum",  sum_a, '0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_nodone_%0d", k), ACC_W'(done_a), '0);
    end
    @(posedge clk); #1;
    run_vec(vt[2], 7);

    // LUT_LAT=3 instance, all segments 31
    s = cyc;
    start_b = 1'b1; upper_b = fill(5'd31);
    @(posedge clk); #1;
    start_b = 1'b0; upper_b = '0;
    got = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done_b) begin
        got = cyc - s;
        break;
      end
    end
    chk("lat3_done_cyc", ACC_W'(got), ACC_W'(12));
    chk("lat3_sum", sum_b, ACC_W'(1116));

    repeat (3) @(posedge clk);
    chk("sb_empty", ACC_W'(sbq.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
